multicycle_control: RTL and testbench

Multi-cycle control unit that drives the full datapath's control inputs from the instruction fields and ALU flags that the datapath exports. Consumes `control` (opcode), `aluControl` ({funct7[5], funct3}), `status` and `zero`. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and produces `PCsrc`, `ALUsrc`, `memReadWrite`, `memToReg`, `RegWrite`, `immSel` and `ALUop`, plus PC/IR write enables and a retired-instruction count. Sits beside the datapath at the top level, same clock.

---
 rtl/ctrl_pkg.sv | 56 +++++
 rtl/alu_decoder.sv | 60 ++++++
 rtl/multicycle_control.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the multi-cycle control unit.
//   - RV32 opcode values handled by the controller
//   - ALU operation codes driven on ALUop
//   - immediate-format selects driven on immSel
//   - controller state enum
package ctrl_pkg;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcIAlu   = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSll  = 4'b0101;
    localparam logic [3:0] AluSrl  = 4'b0110;
    localparam logic [3:0] AluSra  = 4'b0111;
    localparam logic [3:0] AluSlt  = 4'b1000;
    localparam logic [3:0] AluSltu = 4'b1001;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        BR,
        TRAP
    } state_t;

    // funct3 -> ALU operation shared by R and I-ALU formats. alt selects SRA
    // over SRL; the SUB case is resolved by the caller since I-type has none.
    function automatic logic [3:0] f3_to_aluop(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational decode of opcode and {funct7[5], funct3}.
//   opcode_i   - instruction opcode
//   funct_i    - {funct7[5], funct3}
//   alu_op_o   - ALU operation code
//   alu_src_o  - 1 selects the immediate as ALU operand B
//   imm_sel_o  - immediate format (I/S/B)
//   legal_o    - opcode/funct combination is supported
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [3:0] funct_i,
    output logic [3:0] alu_op_o,
    output logic       alu_src_o,
    output logic [1:0] imm_sel_o,
    output logic       legal_o
);

    logic [2:0] f3;
    logic       f7b5;

    assign f3   = funct_i[2:0];
    assign f7b5 = funct_i[3];

    always_comb begin
        alu_op_o  = AluAdd;
        alu_src_o = 1'b0;
        imm_sel_o = ImmI;
        legal_o   = 1'b0;
        case (opcode_i)
            OpcR: begin
                // funct7[5] is only meaningful for ADD/SUB and SRL/SRA
                legal_o  = !f7b5 || (f3 == 3'b000) || (f3 == 3'b101);
                alu_op_o = (f7b5 && f3 == 3'b000) ? AluSub : f3_to_aluop(f3, f7b5);
            end
            OpcIAlu: begin
                legal_o   = 1'b1;
                alu_src_o = 1'b1;
                alu_op_o  = f3_to_aluop(f3, f7b5 && (f3 == 3'b101));
            end
            OpcLoad: begin
                legal_o   = 1'b1;
                alu_src_o = 1'b1;
            end
            OpcStore: begin
                legal_o   = 1'b1;
                alu_src_o = 1'b1;
                imm_sel_o = ImmS;
            end
            OpcBranch: begin
                // funct3 010/011 have no branch meaning
                legal_o   = (f3[2:1] != 2'b01);
                alu_op_o  = AluSub;
                imm_sel_o = ImmB;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB/BR/TRAP sequencer for the
// multi-cycle datapath.
//   clk, rst          - clock, synchronous active-high reset
//   control           - opcode from the datapath
//   aluControl        - {funct7[5], funct3} from the datapath
//   status, zero      - ALU flags {N, Z, C, V} and zero
//   PCsrc, ALUsrc, memReadWrite, memToReg, RegWrite, immSel, ALUop
//                     - datapath controls
//   pc_write, ir_write - PC / IR load enables
//   illegal           - high while trapped on an illegal instruction
//   retired           - wrapping count of completed instructions
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       control,
    input  logic [3:0]       aluControl,
    input  logic [3:0]       status,
    input  logic             zero,
    output logic             PCsrc,
    output logic             ALUsrc,
    output logic             memReadWrite,
    output logic             memToReg,
    output logic             RegWrite,
    output logic [1:0]       immSel,
    output logic [3:0]       ALUop,
    output logic             pc_write,
    output logic             ir_write,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W - 1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [6:0]       opcode_q;
    logic [3:0]       funct_q;
    logic [CNT_W-1:0] retired_q;

    logic [6:0] dec_opcode;
    logic [3:0] dec_funct;
    logic [3:0] dec_alu_op;
    logic       dec_alu_src;
    logic [1:0] dec_imm_sel;
    logic       dec_legal;
    logic       alu_en;
    logic       taken;
    logic       unused_status_z;

    // zero is the authoritative Z flag; status[2] duplicates it
    assign unused_status_z = status[2];

    // In DECODE the fields are not yet latched, so legality is judged on the
    // live inputs; everywhere else only the latched copy is used.
    assign dec_opcode = (state_q == DECODE) ? control : opcode_q;
    assign dec_funct  = (state_q == DECODE) ? aluControl : funct_q;

    alu_decoder u_alu_decoder (
        .opcode_i  (dec_opcode),
        .funct_i   (dec_funct),
        .alu_op_o  (dec_alu_op),
        .alu_src_o (dec_alu_src),
        .imm_sel_o (dec_imm_sel),
        .legal_o   (dec_legal)
    );

    always_comb begin
        case (funct_q[2:0])
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = status[3] ^ status[0];
            3'b101:  taken = !(status[3] ^ status[0]);
            3'b110:  taken = !status[1];
            3'b111:  taken = status[1];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        PCsrc        = 1'b0;
        ALUsrc       = 1'b0;
        memReadWrite = 1'b0;
        memToReg     = 1'b0;
        RegWrite     = 1'b0;
        immSel       = ImmI;
        ALUop        = AluAdd;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        illegal      = 1'b0;
        alu_en       = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                if (!dec_legal) begin
                    state_d = TRAP;
                end else if (dec_opcode == OpcBranch) begin
                    state_d = BR;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_en  = 1'b1;
                state_d = (opcode_q == OpcLoad || opcode_q == OpcStore) ? MEM : WB;
            end
            MEM: begin
                alu_en = 1'b1;
                if (opcode_q == OpcStore) begin
                    memReadWrite = 1'b1;
                    pc_write     = 1'b1;
                    state_d      = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            WB: begin
                alu_en   = 1'b1;
                RegWrite = 1'b1;
                memToReg = (opcode_q == OpcLoad);
                pc_write = 1'b1;
                state_d  = FETCH;
            end
            BR: begin
                alu_en   = 1'b1;
                PCsrc    = taken;
                pc_write = 1'b1;
                state_d  = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // No ALU output register in the datapath: keep the ALU controls
        // steady from EXEC/BR until the instruction retires.
        if (alu_en) begin
            ALUop  = dec_alu_op;
            ALUsrc = dec_alu_src;
            immSel = dec_imm_sel;
        end

        // Suppress every write enable while reset is held so an aborted
        // instruction never commits.
        if (rst) begin
            memReadWrite = 1'b0;
            RegWrite     = 1'b0;
            pc_write     = 1'b0;
            ir_write     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            opcode_q  <= '0;
            funct_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                opcode_q <= control;
                funct_q  <= aluControl;
            end
            if (pc_write) begin
                retired_q <= retired_q + CntOne;
            end
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int KR = 0;
    localparam int KI = 1;
    localparam int KLW = 2;
    localparam int KSW = 3;
    localparam int KBR = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] control;
    logic [3:0] aluControl;
    logic [3:0] status;
    logic       zero;
    logic       PCsrc, ALUsrc, memReadWrite, memToReg, RegWrite;
    logic [1:0] immSel;
    logic [3:0] ALUop;
    logic       pc_write, ir_write, illegal;
    logic [3:0] retired;
    logic [13:0] obs_vec;

    int npass = 0;
    int ntotal = 0;
    int model_ret = 0;
    int r_tab[16];
    int i_tab[8];

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .control      (control),
        .aluControl   (aluControl),
        .status       (status),
        .zero         (zero),
        .PCsrc        (PCsrc),
        .ALUsrc       (ALUsrc),
        .memReadWrite (memReadWrite),
        .memToReg     (memToReg),
        .RegWrite     (RegWrite),
        .immSel       (immSel),
        .ALUop        (ALUop),
        .pc_write     (pc_write),
        .ir_write     (ir_write),
        .illegal      (illegal),
        .retired      (retired)
    );

    assign obs_vec = {PCsrc, ALUsrc, memReadWrite, memToReg, RegWrite, immSel, ALUop,
                      pc_write, ir_write, illegal};

    function automatic logic [13:0] pack(input logic pcsrc, input logic alusrc,
                                         input logic mrw, input logic m2r, input logic rw,
                                         input logic [1:0] imm, input logic [3:0] op,
                                         input logic pcw, input logic irw, input logic ill);
        return {pcsrc, alusrc, mrw, m2r, rw, imm, op, pcw, irw, ill};
    endfunction

    function automatic logic [6:0] opc_of(input int kind);
        case (kind)
            KR:      return 7'b0110011;
            KI:      return 7'b0010011;
            KLW:     return 7'b0000011;
            KSW:     return 7'b0100011;
            default: return 7'b1100011;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One instruction from FETCH to retirement; rst_at > 0 asserts reset in
    // that cycle of the instruction instead of letting it complete.
    task automatic run_instr(input int kind, input logic [3:0] fn, input logic [3:0] st,
                             input int rst_at, input string name);
        logic [3:0] eop;
        logic       esrc;
        logic [1:0] eimm;
        int         lat;
        logic       tk;
        logic       last;
        logic       aborted;
        logic       n, z, c, v;
        n = st[3]; z = st[2]; c = st[1]; v = st[0];
        eop = 4'd0; esrc = 1'b0; eimm = 2'd0; lat = 4; tk = 1'b0; aborted = 1'b0;
        case (kind)
            KR:  eop = 4'(r_tab[fn]);
            KI: begin
                esrc = 1'b1;
                eop  = (fn == 4'b1101) ? 4'd7 : 4'(i_tab[fn[2:0]]);
            end
            KLW: begin esrc = 1'b1; lat = 5; end
            KSW: begin esrc = 1'b1; eimm = 2'd1; end
            default: begin
                eop = 4'd1; eimm = 2'd2; lat = 3;
                case (fn[2:0])
                    3'd0:    tk = z;
                    3'd1:    tk = !z;
                    3'd4:    tk = (n != v);
                    3'd5:    tk = (n == v);
                    3'd6:    tk = !c;
                    default: tk = c;
                endcase
            end
        endcase
        control    = opc_of(kind);
        aluControl = fn;
        status     = 4'($urandom);
        zero       = status[2];
        for (int cyc = 1; cyc <= lat && !aborted; cyc++) begin
            if (cyc == 3) begin
                control    = 7'($urandom);
                aluControl = 4'($urandom);
            end
            if (cyc == lat && kind == KBR) begin
                status = st;
                zero   = st[2];
            end
            if (cyc == rst_at) rst = 1'b1;
            #1;
            last = (cyc == lat) && (cyc != rst_at);
            check($sformatf("%s c%0d", name, cyc), 32'(obs_vec),
                  32'(pack((cyc == lat) && kind == KBR && tk,
                           (cyc >= 3) ? esrc : 1'b0,
                           last && kind == KSW,
                           last && kind == KLW,
                           last && (kind == KR || kind == KI || kind == KLW),
                           (cyc >= 3) ? eimm : 2'd0,
                           (cyc >= 3) ? eop : 4'd0,
                           last, cyc == 1, 1'b0)));
            @(negedge clk);
            if (cyc == rst_at) begin
                rst       = 1'b0;
                aborted   = 1'b1;
                model_ret = 0;
            end
        end
        #1;
        if (aborted) begin
            check({name, " post-rst"}, 32'(obs_vec), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        end else begin
            model_ret = (model_ret + 1) % 16;
        end
        check({name, " retired"}, 32'(retired), 32'(model_ret));
    endtask

    task automatic run_trap(input logic [6:0] opc, input logic [3:0] fn, input string name);
        control    = opc;
        aluControl = fn;
        #1;
        check({name, " fetch"}, 32'(obs_vec), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        @(negedge clk); #1;
        check({name, " decode"}, 32'(obs_vec), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            control    = 7'($urandom);
            aluControl = 4'($urandom);
            #1;
            check($sformatf("%s trap%0d", name, k), 32'(obs_vec),
                  32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
            @(negedge clk);
        end
        check({name, " trap retired"}, 32'(retired), 32'(model_ret));
        rst = 1'b1;
        #1;
        check({name, " rst cycle"}, 32'(obs_vec), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
        @(negedge clk);
        rst = 1'b0;
        model_ret = 0;
        #1;
        check({name, " after rst"}, 32'(obs_vec), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        check({name, " after rst retired"}, 32'(retired), 32'(model_ret));
    endtask

    initial begin
        int kind;
        logic [3:0] fn;
        for (int i = 0; i < 16; i++) r_tab[i] = -1;
        r_tab[0] = 0; r_tab[8] = 1; r_tab[1] = 5; r_tab[2] = 8; r_tab[3] = 9;
        r_tab[4] = 4; r_tab[5] = 6; r_tab[13] = 7; r_tab[6] = 3; r_tab[7] = 2;
        i_tab[0] = 0; i_tab[1] = 5; i_tab[2] = 8; i_tab[3] = 9;
        i_tab[4] = 4; i_tab[5] = 6; i_tab[6] = 3; i_tab[7] = 2;

        rst = 1'b1; control = '0; aluControl = '0; status = '0; zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst held", 32'(obs_vec), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset state", 32'(obs_vec), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        check("reset retired", 32'(retired), 32'(model_ret));

        run_instr(KR, 4'b0000, 4'b0000, 0, "add");
        run_instr(KI, 4'b1101, 4'b0000, 0, "srai");
        run_instr(KI, 4'b1000, 4'b0000, 0, "addi-f7");
        run_instr(KLW, 4'b0010, 4'b0000, 0, "lw");
        run_instr(KSW, 4'b0010, 4'b0000, 0, "sw");
        run_instr(KBR, 4'b0000, 4'b0100, 0, "beq-z");
        run_instr(KBR, 4'b0001, 4'b0100, 0, "bne-z");
        run_instr(KBR, 4'b0100, 4'b1000, 0, "blt-n");

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 4));
            fn   = 4'($urandom);
            if (kind == KR) begin
                while (r_tab[fn] < 0) fn = 4'($urandom);
            end else if (kind == KBR) begin
                while (fn[2:1] == 2'b01) fn = 4'($urandom);
            end
            run_instr(kind, fn, 4'($urandom), 0, $sformatf("rnd%0d", i));
        end

        // Counter wrap: sixteen retirements from zero land back on zero.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_ret = 0;
        for (int i = 0; i < 16; i++) run_instr(KR, 4'b0000, 4'b0000, 0, $sformatf("wrap%0d", i));
        check("wrap zero", 32'(retired), 32'd0);

        run_instr(KR, 4'b0110, 4'b0000, 0, "or");
        run_instr(KLW, 4'b0010, 4'b0000, 4, "lw-rst-mem");
        run_instr(KSW, 4'b0010, 4'b0000, 0, "sw2");

        run_trap(7'b1111111, 4'b0000, "illop");
        run_trap(7'b0110011, 4'b1001, "r-bad");
        run_trap(7'b1100011, 4'b0010, "br-bad");
        run_instr(KBR, 4'b0111, 4'b0010, 0, "bgeu");

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
